// File: rtl/mac_dot_engine.sv
// mac_dot_engine: dual-port RAM with a pipelined multiply-accumulate engine.
// On start it streams vectors A and B from RAM (one pair per clock),
// accumulates their dot product, writes the result back as two words
// (low at base_r, high at base_r+1) and pulses done.
// Optional build macro: MAC_SAT_EN -- clamp the accumulator on overflow
// instead of wrapping.
module mac_dot_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 5,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W:0]     cnt, cnt_nxt, len_q;
    logic [ADDR_W-1:0]   base_a_q, base_b_q, base_r_q;
    logic [ADDR_W-1:0]   addr_a, addr_b;
    logic                we_b, host_wr, run_clr;
    logic [DATA_W-1:0]   wdata_b, rd_a, rd_b;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic                v1, v2;
    logic [ACC_W-1:0]    acc, prod_ext;
    logic [ACC_W:0]      sum_w;
    logic                ovf_now;

    assign host_wr = host_we && !busy;
    assign run_clr = (state == S_IDLE) && start;
    assign cnt_nxt = cnt + 1'b1;

    // Port address/write selection: engine owns port A only while streaming.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        addr_a  = host_addr;
        addr_b  = base_b_q + cnt[ADDR_W-1:0];
        we_b    = 1'b0;
        wdata_b = acc[DATA_W-1:0];
        if (state == S_RUN) addr_a = base_a_q + cnt[ADDR_W-1:0];
        case (state)
            S_WR_LO: begin
                addr_b = base_r_q;
                we_b   = 1'b1;
            end
            S_WR_HI: begin
                addr_b  = base_r_q + 1'b1;
                we_b    = 1'b1;
                wdata_b = acc[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    // RAM write ports: host on A (idle only), engine writeback on B.
    // NOTE: the RAM array is deliberately left without reset so it maps onto block RAM and keeps contents across reset.
    always_ff @(posedge clk) begin
        if (host_wr) mem[host_addr] <= host_wdata;
        if (we_b)    mem[addr_b]    <= wdata_b;
    end

    // Operand extension and product width handling.
    always_comb begin
        ext_a    = {{DATA_W{1'b0}}, rd_a};
        ext_b    = {{DATA_W{1'b0}}, rd_b};
        prod_ext = ACC_W'(prod);
        if (SIGNED != 0) begin
            ext_a    = {{DATA_W{rd_a[DATA_W-1]}}, rd_a};
            ext_b    = {{DATA_W{rd_b[DATA_W-1]}}, rd_b};
            prod_ext = ACC_W'($signed(prod));
        end
        sum_w   = {1'b0, acc} + {1'b0, prod_ext};
        ovf_now = (SIGNED != 0)
                ? ((acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc[ACC_W-1]))
                : sum_w[ACC_W];
    end

`ifdef MAC_SAT_EN
    logic [ACC_W-1:0] sat_val;

    // Clamp target: overflow direction follows the sign of the addend.
    always_comb begin
        sat_val = '1;
        if (SIGNED != 0)
            sat_val = prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif

    // RAM read registers, product stage and host read-back register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a       <= '0;
            rd_b       <= '0;
            v1         <= 1'b0;
            prod       <= '0;
            v2         <= 1'b0;
            host_rdata <= '0;
        end else begin
            // NOTE: non-blocking reads return the pre-write word on a same-address read-during-write.
            rd_a <= mem[addr_a];
            rd_b <= mem[addr_b];
            v1   <= (state == S_RUN);
            prod <= ext_a * ext_b;
            v2   <= v1;
            if (!busy) host_rdata <= mem[host_addr];
        end
    end

    // Accumulator and sticky overflow; only valid products are added.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (run_clr) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (v2) begin
`ifdef MAC_SAT_EN
            if (!overflow) acc <= ovf_now ? sat_val : sum_w[ACC_W-1:0];
`else
            acc <= sum_w[ACC_W-1:0];
`endif
            if (ovf_now) overflow <= 1'b1;
        end
    end

    // Control FSM: sequencing, operand latching and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_r_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    base_a_q <= base_a;
                    base_b_q <= base_b;
                    base_r_q <= base_r;
                    len_q    <= len;
                    cnt      <= '0;
                    busy     <= 1'b1;
                    state    <= (len == '0) ? S_DRAIN : S_RUN;
                end
                S_RUN: begin
                    if (cnt_nxt == len_q) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_DRAIN: begin
                    if (cnt[0]) begin
                        cnt   <= '0;
                        state <= S_WR_LO;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_WR_LO: state <= S_WR_HI;
                S_WR_HI: begin
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= acc;
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_engine.sv
// tb_mac_dot_engine: drives an unsigned (ACC_W=32) and a signed (ACC_W=40)
// instance with identical stimulus and compares both against an arithmetic
// reference model with its own RAM images.
module tb_mac_dot_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_we;
    logic [4:0]  host_addr;
    logic [15:0] host_wdata;
    logic        start;
    logic [4:0]  base_a, base_b, base_r;
    logic [5:0]  len;

    logic [15:0] host_rdata_u, host_rdata_s;
    logic        busy_u, busy_s, done_u, done_s, overflow_u, overflow_s;
    logic [31:0] result_u;
    logic [39:0] result_s;

    logic [15:0] mem_u [32];
    logic [15:0] mem_s [32];
    logic [31:0] exp_u;
    logic [39:0] exp_s;
    bit          exp_ovf_u, exp_ovf_s;

    int vectors = 0;
    int miscompares = 0;

    localparam longint S_MAX  = 64'sh0000_007F_FFFF_FFFF;
    localparam longint S_MIN  = -64'sh0000_0080_0000_0000;
    localparam longint S_SPAN = 64'sh0000_0100_0000_0000;

    always #5 clk = ~clk;

    mac_dot_engine #(.DATA_W(16), .ACC_W(32), .ADDR_W(5), .SIGNED(0)) dut_u (
        .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata_u), .start(start),
        .base_a(base_a), .base_b(base_b), .base_r(base_r), .len(len),
        .busy(busy_u), .done(done_u), .result(result_u), .overflow(overflow_u)
    );

    mac_dot_engine #(.DATA_W(16), .ACC_W(40), .ADDR_W(5), .SIGNED(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata_s), .start(start),
        .base_a(base_a), .base_b(base_b), .base_r(base_r), .len(len),
        .busy(busy_s), .done(done_s), .result(result_s), .overflow(overflow_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Dot product from the arithmetic definition, then writeback into the model RAMs.
    task automatic model_run(input logic [4:0] ba, input logic [4:0] bb,
                             input logic [4:0] br, input logic [5:0] ln);
        longint unsigned acc_u, pu, su;
        longint          acc_s, ps, ss;
        bit              ou, os;
        logic [63:0]     tmp;
        logic [4:0]      ia, ib;
        acc_u = 0; acc_s = 0; ou = 0; os = 0;
        for (int k = 0; k < int'(ln); k++) begin
            ia = ba + 5'(k);
            ib = bb + 5'(k);
            pu = 64'(mem_u[ia]) * 64'(mem_u[ib]);
            su = acc_u + pu;
            ps = longint'($signed(mem_s[ia])) * longint'($signed(mem_s[ib]));
            ss = acc_s + ps;
`ifdef MAC_SAT_EN
            if (!ou) begin
                if (su > 64'hFFFF_FFFF) begin ou = 1; acc_u = 64'hFFFF_FFFF; end
                else acc_u = su;
            end
            if (!os) begin
                if (ss > S_MAX)      begin os = 1; acc_s = S_MAX; end
                else if (ss < S_MIN) begin os = 1; acc_s = S_MIN; end
                else acc_s = ss;
            end
`else
            if (su > 64'hFFFF_FFFF) begin ou = 1; acc_u = su - 64'h1_0000_0000; end
            else acc_u = su;
            if (ss > S_MAX)      begin os = 1; acc_s = ss - S_SPAN; end
            else if (ss < S_MIN) begin os = 1; acc_s = ss + S_SPAN; end
            else acc_s = ss;
`endif
        end
        exp_u     = 32'(acc_u);
        tmp       = acc_s;
        exp_s     = tmp[39:0];
        exp_ovf_u = ou;
        exp_ovf_s = os;
        mem_u[br]        = exp_u[15:0];
        mem_u[br + 5'd1] = exp_u[31:16];
        mem_s[br]        = exp_s[15:0];
        mem_s[br + 5'd1] = exp_s[31:16];
    endtask

    task automatic host_write(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        mem_u[a] = d;
        mem_s[a] = d;
    endtask

    task automatic read_check(input logic [4:0] a);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        check("rd_u", 64'(host_rdata_u), 64'(mem_u[a]));
        check("rd_s", 64'(host_rdata_s), 64'(mem_s[a]));
    endtask

    // One engine run: optional host write on the start edge, optional
    // ignored start/host_we poke while busy, latency and result checks.
    task automatic run_check(input logic [4:0] ba, input logic [4:0] bb,
                             input logic [4:0] br, input logic [5:0] ln,
                             input bit poke, input bit co_wr,
                             input logic [4:0] co_a, input logic [15:0] co_d);
        int cyc;
        if (co_wr) begin
            mem_u[co_a] = co_d;
            mem_s[co_a] = co_d;
        end
        model_run(ba, bb, br, ln);
        @(negedge clk);
        base_a = ba; base_b = bb; base_r = br; len = ln; start = 1'b1;
        host_we = co_wr; host_addr = co_a; host_wdata = co_d;
        @(negedge clk);
        start = 1'b0; host_we = 1'b0;
        check("busy_u", 64'(busy_u), 64'(1));
        check("busy_s", 64'(busy_s), 64'(1));
        cyc = 0;
        while (!done_u && cyc < 200) begin
            if (poke && cyc == 1) begin
                host_we = 1'b1; host_addr = 5'($urandom); host_wdata = 16'($urandom);
                start = 1'b1; base_a = 5'($urandom); base_b = 5'($urandom);
                base_r = 5'($urandom); len = 6'($urandom_range(0, 32));
            end else begin
                host_we = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        host_we = 1'b0; start = 1'b0;
        check("latency", 64'(cyc), 64'(int'(ln) + 4));
        check("done_s", 64'(done_s), 64'(1));
        check("busy_at_done", 64'(busy_u), 64'(0));
        check("result_u", 64'(result_u), 64'(exp_u));
        check("ovf_u", 64'(overflow_u), 64'(exp_ovf_u));
        check("result_s", 64'(result_s), 64'(exp_s));
        check("ovf_s", 64'(overflow_s), 64'(exp_ovf_s));
        @(negedge clk);
        check("done_pulse", 64'(done_u | done_s), 64'(0));
        read_check(br);
        read_check(br + 5'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        reset_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        start = 1'b0; base_a = '0; base_b = '0; base_r = '0; len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_u | busy_s), 64'(0));
        check("rst_done", 64'(done_u | done_s), 64'(0));
        check("rst_result", 64'(result_u) | 64'(result_s), 64'(0));
        check("rst_ovf", 64'(overflow_u | overflow_s), 64'(0));
        check("rst_rdata", 64'(host_rdata_u) | 64'(host_rdata_s), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) host_write(5'(i), 16'($urandom));

        // Basic dot product.
        host_write(0, 4);  host_write(1, 5);  host_write(2, 6);  host_write(3, 7);
        host_write(8, 3);  host_write(9, 3);  host_write(10, 2); host_write(11, 1);
        run_check(0, 8, 16, 4, 1'b1, 1'b0, 0, 0);
        check("dot_46", 64'(result_u), 64'(46));

        // len = 0 writes zeros over non-zero words.
        host_write(20, 16'h1234); host_write(21, 16'h5678);
        run_check(0, 8, 20, 0, 1'b1, 1'b0, 0, 0);
        check("len0_result", 64'(result_u), 64'(0));

        // Address wrap; element at address 0 written on the start edge.
        host_write(30, 1); host_write(31, 2); host_write(0, 16'hBEEF);
        host_write(14, 10); host_write(15, 10); host_write(16, 10);
        run_check(30, 14, 20, 3, 1'b0, 1'b1, 0, 3);
        check("wrap_60", 64'(result_u), 64'(60));

        // Signed operands.
        host_write(4, 16'hFFFD); host_write(5, 2);
        host_write(6, 5);        host_write(7, 16'hFFFC);
        run_check(4, 6, 12, 2, 1'b1, 1'b0, 0, 0);
        check("signed_m23", 64'(result_s), 64'(40'hFF_FFFF_FFE9));
        host_addr = 12; @(negedge clk); @(negedge clk);
        check("signed_lo", 64'(host_rdata_s), 64'(16'hFFE9));
        host_addr = 13; @(negedge clk); @(negedge clk);
        check("signed_hi", 64'(host_rdata_s), 64'(16'hFFFF));

        // Unsigned overflow.
        host_write(26, 16'hFFFF); host_write(27, 16'hFFFF);
        run_check(26, 26, 28, 2, 1'b0, 1'b0, 0, 0);
        check("ovf_flag", 64'(overflow_u), 64'(1));
`ifdef MAC_SAT_EN
        check("ovf_result", 64'(result_u), 64'(32'hFFFF_FFFF));
`else
        check("ovf_result", 64'(result_u), 64'(32'hFFFC_0002));
`endif

        // Reset mid-run aborts with no writeback.
        host_write(22, 16'hA5A5); host_write(23, 16'h5A5A);
        @(negedge clk);
        base_a = 0; base_b = 8; base_r = 22; len = 10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_u | busy_s), 64'(0));
        check("abort_result", 64'(result_u) | 64'(result_s), 64'(0));
        check("abort_ovf", 64'(overflow_u | overflow_s), 64'(0));
        check("abort_rdata", 64'(host_rdata_u), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_u || done_s) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'(0));
        read_check(22);
        read_check(23);
        check("abort_ram", 64'(host_rdata_u), 64'(16'h5A5A));

        // Randomized runs.
        for (int it = 0; it < 24; it++) begin
            for (int w = 0; w < 3; w++) host_write(5'($urandom), 16'($urandom));
            run_check(5'($urandom), 5'($urandom), 5'($urandom),
                      6'($urandom_range(0, 32)), 1'b1, 1'($urandom),
                      5'($urandom), 16'($urandom));
            read_check(5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
